ror_arbiter: RTL and testbench
==============================

ROR_ARBITER -- requirements
Module: ror_arbiter

Interface
REQ-001 Parameter: FAIR, 1, 1 = round-robin grant; 0 = fixed priority to requester 0.
REQ-002 Parameter: CNT_W, 8, width of per-requester saturating grant counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req0_valid / req1_valid  in  1  requester k has an operation pending.
REQ-006 req0_a / req1_a  in  5  operand to rotate right.
REQ-007 req0_sh / req1_sh  in  3  rotate amount, 0-7.
REQ-008 req0_ready / req1_ready  out  1  operand accepted this cycle (valid & ready).
REQ-009 rsp_valid  out  1  result bus holds a completed operation.
REQ-010 rsp_ready  in  1  consumer takes result (valid & ready).
REQ-011 rsp_id  out  1  requester that issued the result.
REQ-012 rsp_z  out  5  rotated result; rsp_cf, rsp_sf, rsp_zf  out  1 each  flags.
REQ-013 gnt_cnt0 / gnt_cnt1  out  CNT_W  accepted-operation count per requester.

Function
REQ-014 FSM states IDLE, EXEC, RESP; one operation in flight at most.
REQ-015 IDLE: if any reqk_valid, grant one; reqk_ready = 1 for the granted requester only, combinationally, only in IDLE; operand and rotate amount latched; next EXEC.
REQ-016 IDLE with no valid: stay IDLE, both readys 0.
REQ-017 Both valid in IDLE, FAIR=1: grant requester named by priority pointer; FAIR=0: grant requester 0.
REQ-018 Priority pointer toggles to the non-granted requester on each accept (FAIR=1 only).
REQ-019 EXEC: latched operand drives one shared rotate unit; effective amount = sh mod 5 (5->0, 6->1, 7->2); result and flags registered; next RESP.
REQ-020 Flags: sf = z[4]; zf = (z == 0); cf = z[4] if effective amount != 0, else 0.
REQ-021 RESP: rsp_valid = 1; rsp_id, rsp_z and flags stable until rsp_ready; on rsp_ready go IDLE.
REQ-022 Latency: accept in cycle N -> rsp_valid first high in cycle N+2; accept possible again in the cycle after rsp handshake.
REQ-023 rsp_ready low in RESP: hold indefinitely, no new accept, readys 0.
REQ-024 Requester may drop valid before grant without effect; inputs ignored outside the accept cycle.
REQ-025 gnt_cntk increments on each accept by requester k; saturates at all-ones, no wrap.
REQ-026 rsp_* outputs 0 whenever rsp_valid = 0.

Reset
REQ-027 rst_n low: state IDLE, pointer = requester 0, all outputs 0, counters 0, latched operand 0, immediately (async).
REQ-028 Reset during EXEC or RESP: in-flight operation discarded, no response emitted after release.
REQ-029 First accept possible on the first rising clk edge with rst_n high.

Structure
REQ-030 Shared package ror_pkg: FSM state encoding, operand width 5, amount width 3, modulus 5.
REQ-031 One sub-module: the existing ror_5bit rotate unit, instantiated once; mod-5 reduction and flag masking in ror_arbiter.
REQ-032 Target 120-400 lines RTL; no latches; single clock domain.

Verification
REQ-033 req0 a=11100 sh=001 -> rsp_z=01110, cf0 sf0 zf0, rsp_id0, rsp_valid 2 cycles after accept.
REQ-034 req1 a=11100 sh=101 -> z=11100, cf0 sf1 zf0; sh=111 -> z=00111, cf0 sf0 zf0.
REQ-035 a=00001 sh=001 -> z=10000, cf1 sf1 zf0; a=00000 sh=011 -> z=00000, zf1 cf0 sf0.
REQ-036 Both valid continuously, FAIR=1, rsp_ready=1 -> grants alternate 0,1,0,1; FAIR=0 -> always 0; gnt_cnt values match.
REQ-037 rsp_ready held 0 for 10 cycles in RESP -> rsp fields stable, readys 0; rst_n pulsed low in EXEC -> no rsp, state IDLE, counters 0.
REQ-038 CNT_W=2, 5 accepts by requester 0 -> gnt_cnt0 = 11 (saturated).

Source files
------------

// File: rtl/ror_pkg.sv
// Shared definitions for the rotate-right arbiter: datapath widths,
// FSM state encoding and the rotate-amount reduction.
package ror_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned SH_W    = 3;
    localparam int unsigned ROT_MOD = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Rotating a 5-bit operand by 5 is the identity, so 5..7 fold onto 0..2.
    function automatic logic [SH_W-1:0] mod_amt(input logic [SH_W-1:0] sh);
        return (sh >= SH_W'(ROT_MOD)) ? sh - SH_W'(ROT_MOD) : sh;
    endfunction

endpackage

// File: rtl/ror_5bit.sv
// 5-bit rotate-right unit; amount is expected already reduced to 0..4.
module ror_5bit
    import ror_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [SH_W-1:0] sh,
    output logic [OP_W-1:0] z
);

    assign z = OP_W'({a, a} >> sh);

endmodule

// File: rtl/ror_arbiter.sv
// Two-requester arbiter in front of one shared rotate-right unit, with
// a single operation in flight and per-requester saturating grant counts.
module ror_arbiter
    import ror_pkg::*;
#(
    parameter int unsigned FAIR  = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [OP_W-1:0]  req0_a,
    input  logic [SH_W-1:0]  req0_sh,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OP_W-1:0]  req1_a,
    input  logic [SH_W-1:0]  req1_sh,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [OP_W-1:0]  rsp_z,
    output logic             rsp_cf,
    output logic             rsp_sf,
    output logic             rsp_zf,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    state_t           state, state_nx;
    logic             ptr;
    logic             gnt_id;
    logic             accept;
    logic             id_q;
    logic [OP_W-1:0]  a_q;
    logic [SH_W-1:0]  sh_q;
    logic [SH_W-1:0]  amt;
    logic [OP_W-1:0]  rot_z;
    logic [OP_W-1:0]  z_q;
    logic             cf_q, sf_q, zf_q;
    logic [CNT_W-1:0] cnt0, cnt1;

    always_comb begin
        gnt_id = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = (FAIR != 0) ? ptr : 1'b0;
        end else begin
            gnt_id = req1_valid;
        end
    end

    // Readys are gated by rst_n so every output is quiet while reset is held.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        req0_ready = accept & ~gnt_id;
        req1_ready = accept & gnt_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign amt = mod_amt(sh_q);

    ror_5bit u_ror (
        .a  (a_q),
        .sh (amt),
        .z  (rot_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr  <= 1'b0;
            id_q <= 1'b0;
            a_q  <= '0;
            sh_q <= '0;
            z_q  <= '0;
            cf_q <= 1'b0;
            sf_q <= 1'b0;
            zf_q <= 1'b0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (accept) begin
                id_q <= gnt_id;
                a_q  <= gnt_id ? req1_a : req0_a;
                sh_q <= gnt_id ? req1_sh : req0_sh;
                if (FAIR != 0) begin
                    ptr <= ~gnt_id;
                end
                if (!gnt_id && cnt0 != '1) begin
                    cnt0 <= cnt0 + CNT_W'(1);
                end
                if (gnt_id && cnt1 != '1) begin
                    cnt1 <= cnt1 + CNT_W'(1);
                end
            end
            if (state == EXEC) begin
                z_q  <= rot_z;
                sf_q <= rot_z[OP_W-1];
                zf_q <= (rot_z == '0);
                cf_q <= (amt != '0) & rot_z[OP_W-1];
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = rsp_valid & id_q;
    assign rsp_z     = rsp_valid ? z_q : '0;
    assign rsp_cf    = rsp_valid & cf_q;
    assign rsp_sf    = rsp_valid & sf_q;
    assign rsp_zf    = rsp_valid & zf_q;
    assign gnt_cnt0  = cnt0;
    assign gnt_cnt1  = cnt1;

endmodule

// File: tb/tb_ror_arbiter.sv
// Scoreboard bench: two arbiters (round-robin/8-bit counters and
// fixed-priority/2-bit counters) share one randomized stimulus stream.
module tb_ror_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [4:0] req0_a, req1_a;
    logic [2:0] req0_sh, req1_sh;
    logic       rsp_ready;

    logic       rdy0 [2];
    logic       rdy1 [2];
    logic       rv   [2];
    logic       rid  [2];
    logic [4:0] rz   [2];
    logic       rcf  [2];
    logic       rsf  [2];
    logic       rzf  [2];
    logic [7:0] cnt0 [2];
    logic [7:0] cnt1 [2];
    logic [1:0] cnt0_b, cnt1_b;

    ror_arbiter #(.FAIR(1), .CNT_W(8)) u_fair (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_sh(req0_sh), .req0_ready(rdy0[0]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_sh(req1_sh), .req1_ready(rdy1[0]),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_z(rz[0]),
        .rsp_cf(rcf[0]), .rsp_sf(rsf[0]), .rsp_zf(rzf[0]),
        .gnt_cnt0(cnt0[0]), .gnt_cnt1(cnt1[0])
    );

    ror_arbiter #(.FAIR(0), .CNT_W(2)) u_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_sh(req0_sh), .req0_ready(rdy0[1]),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_sh(req1_sh), .req1_ready(rdy1[1]),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_z(rz[1]),
        .rsp_cf(rcf[1]), .rsp_sf(rsf[1]), .rsp_zf(rzf[1]),
        .gnt_cnt0(cnt0_b), .gnt_cnt1(cnt1_b)
    );

    assign cnt0[1] = {6'd0, cnt0_b};
    assign cnt1[1] = {6'd0, cnt1_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        id;
        logic [4:0]  z;
        logic        cf;
        logic        sf;
        logic        zf;
        logic [31:0] first;
    } exp_t;

    exp_t sbq [2][$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[dut%0d] cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
    endtask

    // Reference model: rotate by arithmetic, grant by the stated priority rules.
    function automatic logic [4:0] rot_ref(input logic [4:0] a, input logic [2:0] sh);
        int v, r;
        v = int'(a);
        r = int'(sh) % 5;
        return 5'((v >> r) | (v << (5 - r)));
    endfunction

    int   fair [2] = '{1, 0};
    int   cmax [2] = '{255, 3};
    logic m_busy = 1'b0;
    int   m_from = 0;
    logic m_ptr [2] = '{1'b0, 1'b0};
    int   m_n0 [2] = '{0, 0};
    int   m_n1 [2] = '{0, 0};

    always @(negedge clk) begin
        logic       any, g;
        logic [4:0] za, zr;
        logic [2:0] s;
        exp_t       e;
        if (!rst_n) begin
            m_busy = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_ptr[d] = 1'b0;
                m_n0[d]  = 0;
                m_n1[d]  = 0;
                sbq[d].delete();
                check("reset_ready", d, {30'd0, rdy1[d], rdy0[d]}, 32'd0);
                check("reset_cnt", d, {16'd0, cnt1[d], cnt0[d]}, 32'd0);
            end
        end else begin
            any = req0_valid | req1_valid;
            for (int d = 0; d < 2; d++) begin
                check("gnt_cnt0", d, 32'(cnt0[d]), 32'((m_n0[d] < cmax[d]) ? m_n0[d] : cmax[d]));
                check("gnt_cnt1", d, 32'(cnt1[d]), 32'((m_n1[d] < cmax[d]) ? m_n1[d] : cmax[d]));
            end
            if (m_busy) begin
                for (int d = 0; d < 2; d++)
                    check("busy_ready", d, {30'd0, rdy1[d], rdy0[d]}, 32'd0);
                if (cyc >= m_from && rsp_ready) m_busy = 1'b0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    g = (req0_valid && req1_valid) ? ((fair[d] != 0) ? m_ptr[d] : 1'b0) : req1_valid;
                    check("ready", d, {30'd0, rdy1[d], rdy0[d]}, {30'd0, any & g, any & ~g});
                    if (any) begin
                        za = g ? req1_a : req0_a;
                        s  = g ? req1_sh : req0_sh;
                        zr = rot_ref(za, s);
                        e.id    = g;
                        e.z     = zr;
                        e.sf    = zr[4];
                        e.zf    = (zr == 5'd0);
                        e.cf    = ((int'(s) % 5) != 0) && zr[4];
                        e.first = 32'(cyc + 2);
                        sbq[d].push_back(e);
                        if (fair[d] != 0) m_ptr[d] = ~g;
                        if (g) m_n1[d]++;
                        else m_n0[d]++;
                    end
                end
                if (any) begin
                    m_busy = 1'b1;
                    m_from = cyc + 2;
                end
            end
        end
    end

    logic newr [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                newr[d] = 1'b1;
                check("reset_rsp", d, {23'd0, rv[d], rid[d], rz[d], rcf[d], rsf[d], rzf[d]}, 32'd0);
            end else if (!rv[d]) begin
                check("rsp_idle_zero", d, {24'd0, rid[d], rz[d], rcf[d], rsf[d], rzf[d]}, 32'd0);
                if (newr[d] && sbq[d].size() != 0 && cyc >= int'(sbq[d][0].first))
                    check("rsp_missing", d, {31'd0, rv[d]}, 32'd1);
            end else if (sbq[d].size() == 0) begin
                check("rsp_unexpected", d, {31'd0, rv[d]}, 32'd0);
            end else begin
                e = sbq[d][0];
                if (newr[d]) begin
                    check("rsp_latency", d, 32'(cyc), e.first);
                    newr[d] = 1'b0;
                end
                check("rsp_fields", d, {23'd0, rid[d], rz[d], rcf[d], rsf[d], rzf[d]},
                      {23'd0, e.id, e.z, e.cf, e.sf, e.zf});
                if (rsp_ready) begin
                    void'(sbq[d].pop_front());
                    newr[d] = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic k, input logic [4:0] a, input logic [2:0] sh);
        if (k) begin
            req1_valid = 1'b1; req1_a = a; req1_sh = sh;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_sh = sh;
        end
        rsp_ready = 1'b1;
        tick(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick(3);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req1_a = '0; req0_sh = '0; req1_sh = '0;
        rsp_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;

        send(1'b0, 5'b11100, 3'b001);
        send(1'b1, 5'b11100, 3'b101);
        send(1'b1, 5'b11100, 3'b111);
        send(1'b0, 5'b00001, 3'b001);
        send(1'b0, 5'b00000, 3'b011);

        // Back-pressure: result held while a competing request waits.
        req0_valid = 1'b1; req0_a = 5'b10110; req0_sh = 3'd2;
        rsp_ready = 1'b0;
        tick(1);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 5'b01011; req1_sh = 3'd6;
        tick(12);
        rsp_ready = 1'b1;
        tick(2);
        req1_valid = 1'b0;
        tick(4);

        // Both requesting continuously with the consumer always ready.
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            req0_a = 5'($urandom); req0_sh = 3'($urandom);
            req1_a = 5'($urandom); req1_sh = 3'($urandom);
            tick(1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(4);

        // Reset pulsed while an operation sits in EXEC.
        req0_valid = 1'b1; req0_a = 5'b11111; req0_sh = 3'd1;
        tick(1);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(5);

        for (int i = 0; i < 600; i++) begin
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_a = 5'($urandom); req0_sh = 3'($urandom);
            req1_a = 5'($urandom); req1_sh = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end

        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick(6);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check("drain", d, 32'(sbq[d].size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
